flash_read_arbiter: RTL and testbench

Shares the single flashNavigator SPI flash reader among NUM_REQ independent requesters (e.g. font loader, sprite loader, CPU). It serialises read requests with round-robin fairness and drives the navigator's readAddress/enable pair. It returns each completed MEMORY_LENGTH-byte buffer to the requester that issued the read, and bounds every transaction with a timeout. It sits between the consumer blocks and flashNavigator in the top level.

---
 rtl/flash_read_arbiter.sv | 152 +++++++++++++++
 tb/tb_flash_read_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one flashNavigator SPI reader among NUM_REQ requesters.
// Serialises reads, routes each captured buffer back to its requester, and aborts stalled reads.
module flash_read_arbiter #(
  parameter int          NUM_REQ       = 3,
  parameter int          MEMORY_LENGTH = 5,
  parameter logic [31:0] TIMEOUT       = 32'd1000000
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic [NUM_REQ-1:0]         reqValid,
  input  logic [24*NUM_REQ-1:0]      reqAddress,
  output logic [NUM_REQ-1:0]         reqGrant,
  output logic [NUM_REQ-1:0]         respValid,
  output logic                       respError,
  output logic [MEMORY_LENGTH*8-1:0] respData,
  output logic                       busy,
  output logic [23:0]                navAddress,
  output logic                       navEnable,
  input  logic [MEMORY_LENGTH*8-1:0] navDataBuffer,
  input  logic                       navDataReady
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DATA_W = MEMORY_LENGTH * 8;
  localparam logic [NUM_REQ-1:0] GRANT_0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [23:0]        nav_address_q, nav_address_d;
  logic               nav_enable_q, nav_enable_d;
  logic [NUM_REQ-1:0] req_grant_q, req_grant_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic               resp_error_q, resp_error_d;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;
  logic [31:0]        timeout_count_q, timeout_count_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [23:0]        pick_addr;

  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int step);
    return IDX_W'((int'(base) + step) % NUM_REQ);
  endfunction

  // Search begins one past the last winner so the previous winner is considered last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_addr  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_found && reqValid[rr_index(last_grant_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_index(last_grant_q, k);
        pick_addr  = reqAddress[24*rr_index(last_grant_q, k) +: 24];
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    winner_d        = winner_q;
    nav_address_d   = nav_address_q;
    nav_enable_d    = nav_enable_q;
    req_grant_d     = req_grant_q;
    resp_valid_d    = '0;
    resp_error_d    = 1'b0;
    resp_data_d     = resp_data_q;
    timeout_count_d = timeout_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          winner_d        = pick_idx;
          last_grant_d    = pick_idx;
          nav_address_d   = pick_addr;
          req_grant_d     = GRANT_0 << pick_idx;
          nav_enable_d    = 1'b1;
          timeout_count_d = '0;
          state_d         = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (timeout_count_q != '1) timeout_count_d = timeout_count_q + 32'd1;
        // Data arriving on the timeout cycle still counts as a good read.
        if (navDataReady) begin
          resp_data_d  = navDataBuffer;
          resp_valid_d = GRANT_0 << winner_q;
          nav_enable_d = 1'b0;
          req_grant_d  = '0;
          state_d      = S_RELEASE;
        end else if (timeout_count_q == TIMEOUT - 32'd1) begin
          resp_valid_d = GRANT_0 << winner_q;
          resp_error_d = 1'b1;
          nav_enable_d = 1'b0;
          req_grant_d  = '0;
          state_d      = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // The navigator holds dataReady until it sees enable low; wait it out.
        if (!navDataReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q         <= S_IDLE;
      last_grant_q    <= IDX_W'(NUM_REQ - 1);
      winner_q        <= '0;
      nav_address_q   <= '0;
      nav_enable_q    <= 1'b0;
      req_grant_q     <= '0;
      resp_valid_q    <= '0;
      resp_error_q    <= 1'b0;
      resp_data_q     <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      winner_q        <= winner_d;
      nav_address_q   <= nav_address_d;
      nav_enable_q    <= nav_enable_d;
      req_grant_q     <= req_grant_d;
      resp_valid_q    <= resp_valid_d;
      resp_error_q    <= resp_error_d;
      resp_data_q     <= resp_data_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign reqGrant   = req_grant_q;
  assign respValid  = resp_valid_q;
  assign respError  = resp_error_q;
  assign respData   = resp_data_q;
  assign busy       = (state_q != S_IDLE);
  assign navAddress = nav_address_q;
  assign navEnable  = nav_enable_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench for flash_read_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin model with a navigator stand-in.
`timescale 1ns/1ps
module tb_flash_read_arbiter;

  localparam int NUM_REQ       = 3;
  localparam int MEMORY_LENGTH = 5;
  localparam int TIMEOUT       = 250;
  localparam int DW            = MEMORY_LENGTH * 8;

  logic                  clk = 1'b0;
  logic                  resetN;
  logic [NUM_REQ-1:0]    req_valid;
  logic [23:0]           req_addr [NUM_REQ];
  logic [24*NUM_REQ-1:0] req_address;
  logic [NUM_REQ-1:0]    req_grant;
  logic [NUM_REQ-1:0]    resp_valid;
  logic                  resp_error;
  logic [DW-1:0]         resp_data;
  logic                  busy;
  logic [23:0]           nav_address;
  logic                  nav_enable;
  logic [DW-1:0]         nav_buf;
  logic                  nav_ready;

  always #5 clk = ~clk;

  always_comb begin
    req_address = '0;
    for (int i = 0; i < NUM_REQ; i++) req_address[24*i +: 24] = req_addr[i];
  end

  flash_read_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .MEMORY_LENGTH(MEMORY_LENGTH),
    .TIMEOUT      (32'(TIMEOUT))
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .reqValid     (req_valid),
    .reqAddress   (req_address),
    .reqGrant     (req_grant),
    .respValid    (resp_valid),
    .respError    (resp_error),
    .respData     (resp_data),
    .busy         (busy),
    .navAddress   (nav_address),
    .navEnable    (nav_enable),
    .navDataBuffer(nav_buf),
    .navDataReady (nav_ready)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  int            last_grant;
  logic [DW-1:0] exp_data;
  int            waits [NUM_REQ];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration rule: first pending requester after the previous winner.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic assert_req(input int i, input logic [23:0] a);
    req_valid[i] = 1'b1;
    req_addr[i]  = a;
    waits[i]     = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},   req_grant,   '0);
    check({tag, "_rvalid"},  resp_valid,  '0);
    check({tag, "_rerror"},  resp_error,  '0);
    check({tag, "_rdata"},   resp_data,   '0);
    check({tag, "_busy"},    busy,        '0);
    check({tag, "_naddr"},   nav_address, '0);
    check({tag, "_nenable"}, nav_enable,  '0);
  endtask

  task automatic do_reset();
    resetN    = 1'b0;
    req_valid = '0;
    nav_ready = 1'b0;
    tick();
    check_reset_outputs("reset");
    resetN     = 1'b1;
    last_grant = NUM_REQ - 1;
    exp_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) waits[i] = 0;
  endtask

  // One full transaction starting with the DUT idle and at least one request pending.
  task automatic run_txn(input int lat, input bit tmo, input int sticky, input int drop_mid,
                         input logic [DW-1:0] data, output logic [NUM_REQ-1:0] granted);
    int w;
    logic [NUM_REQ-1:0] oh;
    w = rr_pick(req_valid, last_grant);
    granted = '0;
    if (w < 0) begin
      check("txn_without_request", 1, 0);
      return;
    end
    oh = '0;
    oh[w] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (i != w && req_valid[i]) waits[i]++;
    tick();
    granted = req_grant;
    check("grant", req_grant, oh);
    check("nav_enable_rise", nav_enable, 1);
    check("nav_address", nav_address, req_addr[w]);
    check("busy_active", busy, 1);
    for (int i = 0; i < NUM_REQ; i++)
      if (i != w && req_valid[i]) check("fairness_wait", waits[i] <= NUM_REQ - 1, 1);
    waits[w]   = 0;
    last_grant = w;

    if (tmo) begin
      for (int i = 0; i < TIMEOUT - 1; i++) begin
        tick();
        check("timeout_hold", {resp_valid, nav_enable, req_grant}, {{NUM_REQ{1'b0}}, 1'b1, oh});
      end
      tick();
      check("timeout_valid", resp_valid, oh);
      check("timeout_error", resp_error, 1);
      check("timeout_data_kept", resp_data, exp_data);
    end else begin
      for (int i = 0; i < lat; i++) begin
        if (drop_mid >= 0 && i == lat / 2) req_valid[drop_mid] = 1'b0;
        tick();
        check("active_hold", {resp_valid, nav_enable, req_grant}, {{NUM_REQ{1'b0}}, 1'b1, oh});
      end
      nav_buf   = data;
      nav_ready = 1'b1;
      tick();
      check("resp_valid", resp_valid, oh);
      check("resp_error", resp_error, 0);
      check("resp_data", resp_data, data);
      exp_data = data;
    end
    check("nav_enable_drop", nav_enable, 0);
    check("grant_drop", req_grant, 0);
    check("busy_release", busy, 1);
    req_valid[w] = 1'b0;

    if (!tmo) begin
      for (int i = 0; i < sticky; i++) begin
        tick();
        check("release_hold", {busy, nav_enable, resp_valid}, {1'b1, 1'b0, {NUM_REQ{1'b0}}});
      end
      nav_ready = 1'b0;
    end
    tick();
    check("release_exit", {busy, nav_enable, resp_valid, req_grant}, '0);
  endtask

  initial begin
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] e;
    int w;

    resetN = 1'b0;
    req_valid = '0;
    nav_ready = 1'b0;
    nav_buf = '0;
    for (int i = 0; i < NUM_REQ; i++) req_addr[i] = '0;
    tick();
    do_reset();
    tick();
    check("idle_after_reset", {busy, nav_enable, req_grant}, '0);

    // Single request returning "hello" after 200 cycles.
    assert_req(1, 24'h001000);
    run_txn(200, 1'b0, 0, -1, 40'h68656c6c6f, g);
    check("hello_grant", g, 3'b010);
    check("hello_data", resp_data, 40'h68656c6c6f);

    // Timeout: navigator stays silent.
    assert_req(0, 24'($urandom));
    run_txn(0, 1'b1, 0, -1, '0, g);

    // Ready arrives on the timeout cycle: data wins.
    assert_req(2, 24'($urandom));
    run_txn(TIMEOUT - 1, 1'b0, 0, -1, rand_data(), g);

    // Sticky ready with another requester waiting.
    assert_req(0, 24'($urandom));
    assert_req(2, 24'($urandom));
    run_txn(5, 1'b0, 10, -1, rand_data(), g);
    check("sticky_first", g, 3'b001);
    run_txn(3, 1'b0, 0, -1, rand_data(), g);
    check("sticky_second", g, 3'b100);

    // Requester drops reqValid mid-read; response still delivered.
    assert_req(1, 24'($urandom));
    run_txn(20, 1'b0, 0, 1, rand_data(), g);
    check("drop_grant", g, 3'b010);

    // Contention from reset: strict 0,1,2,0,1,2 order.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) assert_req(i, 24'($urandom));
    for (int n = 0; n < 6; n++) begin
      run_txn(int'($urandom_range(0, 30)), 1'b0, 0, -1, rand_data(), g);
      e = '0;
      e[n % NUM_REQ] = 1'b1;
      check("contention_order", g, e);
      assert_req(n % NUM_REQ, 24'($urandom));
    end

    // Reset in the middle of an active read.
    do_reset();
    assert_req(0, 24'($urandom));
    run_txn(10, 1'b0, 0, -1, rand_data(), g);
    assert_req(1, 24'($urandom));
    w = rr_pick(req_valid, last_grant);
    tick();
    e = '0;
    e[w] = 1'b1;
    check("midreset_grant", req_grant, e);
    repeat (5) begin
      tick();
      check("midreset_active", nav_enable, 1);
    end
    resetN = 1'b0;
    tick();
    check_reset_outputs("midreset");
    resetN = 1'b1;
    last_grant = NUM_REQ - 1;
    exp_data = '0;
    for (int i = 0; i < NUM_REQ; i++) assert_req(i, 24'($urandom));
    run_txn(15, 1'b0, 0, -1, rand_data(), g);
    check("midreset_first_winner", g, 3'b001);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) assert_req(i, 24'($urandom));
      if (req_valid == '0) begin
        repeat ($urandom_range(1, 3)) begin
          tick();
          check("idle_quiet", {busy, nav_enable, req_grant}, '0);
        end
        assert_req(int'($urandom_range(0, NUM_REQ - 1)), 24'($urandom));
      end
      run_txn(int'($urandom_range(0, 60)), ($urandom_range(0, 9) == 0),
              int'($urandom_range(0, 3)), -1, rand_data(), g);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
